// File: rtl/compress_handler.sv
// ----------------------------------------------------------------------------
// compress_handler
// Run-length encoder for a bit stream read byte-by-byte from RAM. Bytes are
// taken MSB first; each run is emitted as a 16-bit word {count, value} with
// count 1..255 and value 8'h00 / 8'h01. Runs longer than 255 are split.
//
// Ports:
//   clk            sole clock, rising edge
//   RST            asynchronous active-high reset
//   start          begin compression (sampled in IDLE only)
//   baseAddress    first RAM byte address
//   byteCount      number of bytes to compress (0 is legal)
//   ramAddress     RAM read address
//   ramReadSignal  RAM read request (held in FETCH)
//   ramDoneRead    RAM read complete, ramDataIn valid in the same cycle
//   ramDataIn      RAM read data
//   Dout           compressed word {run length, bit value}
//   doutValid      Dout valid (EMIT state)
//   doutReady      consumer accepts Dout
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse
//
// Optional feature: define COMPRESS_TRAILER_EN to append a terminator word
// 16'h0000 after the final run (also emitted alone when byteCount is 0).
// ----------------------------------------------------------------------------
module compress_handler (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] baseAddress,
    input  logic [15:0] byteCount,
    output logic [15:0] ramAddress,
    output logic        ramReadSignal,
    input  logic        ramDoneRead,
    input  logic [7:0]  ramDataIn,
    output logic [15:0] Dout,
    output logic        doutValid,
    input  logic        doutReady,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SCAN  = 3'd2,
        EMIT  = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    state_t      ret_reg, ret_next;          // where EMIT goes after its handshake
    logic [15:0] addr_reg, addr_next;
    logic [15:0] remaining_reg, remaining_next;
    logic [7:0]  data_reg, data_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  count_reg, count_next;
    logic        value_reg, value_next;
    logic        open_reg, open_next;        // a run has been opened
    logic [15:0] dout_reg, dout_next;

    logic        cur_bit;
    state_t      after_byte;

    assign cur_bit    = data_reg[bit_idx_reg];
    // Destination once bit 0 of the current byte has been consumed.
    assign after_byte = (remaining_reg != 16'd0) ? FETCH : FLUSH;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            ret_reg       <= IDLE;
            addr_reg      <= 16'd0;
            remaining_reg <= 16'd0;
            data_reg      <= 8'd0;
            bit_idx_reg   <= 3'd0;
            count_reg     <= 8'd0;
            value_reg     <= 1'b0;
            open_reg      <= 1'b0;
            dout_reg      <= 16'd0;
        end else begin
            state_reg     <= state_next;
            ret_reg       <= ret_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            data_reg      <= data_next;
            bit_idx_reg   <= bit_idx_next;
            count_reg     <= count_next;
            value_reg     <= value_next;
            open_reg      <= open_next;
            dout_reg      <= dout_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ret_next       = ret_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        data_next      = data_reg;
        bit_idx_next   = bit_idx_reg;
        count_next     = count_reg;
        value_next     = value_reg;
        open_next      = open_reg;
        dout_next      = dout_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    addr_next      = baseAddress;
                    remaining_next = byteCount;
                    open_next      = 1'b0;
                    count_next     = 8'd0;
                    value_next     = 1'b0;
                    if (byteCount != 16'd0) begin
                        state_next = FETCH;
                    end else begin
`ifdef COMPRESS_TRAILER_EN
                        state_next = FLUSH;   // no run open: terminator only
`else
                        state_next = DONE;
`endif
                    end
                end
            end
            FETCH: begin
                if (ramDoneRead) begin
                    data_next      = ramDataIn;
                    addr_next      = addr_reg + 16'd1;
                    remaining_next = remaining_reg - 16'd1;
                    bit_idx_next   = 3'd7;
                    state_next     = SCAN;
                end
            end
            SCAN: begin
                // Index wraps 0->7 on the last bit; FETCH reloads it anyway.
                bit_idx_next = bit_idx_reg - 3'd1;
                state_next   = (bit_idx_reg == 3'd0) ? after_byte : SCAN;
                if (!open_reg) begin
                    open_next  = 1'b1;
                    count_next = 8'd1;
                    value_next = cur_bit;
                end else if ((cur_bit == value_reg) && (count_reg != 8'd255)) begin
                    count_next = count_reg + 8'd1;
                end else begin
                    dout_next  = {count_reg, 7'd0, value_reg};
                    count_next = 8'd1;
                    value_next = cur_bit;
                    ret_next   = (bit_idx_reg == 3'd0) ? after_byte : SCAN;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (doutReady) begin
                    state_next = ret_reg;
                end
            end
            FLUSH: begin
                state_next = EMIT;
`ifdef COMPRESS_TRAILER_EN
                // Final run first, then come back here for the terminator.
                if (open_reg) begin
                    dout_next = {count_reg, 7'd0, value_reg};
                    open_next = 1'b0;
                    ret_next  = FLUSH;
                end else begin
                    dout_next = 16'h0000;
                    ret_next  = DONE;
                end
`else
                dout_next = {count_reg, 7'd0, value_reg};
                ret_next  = DONE;
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ramAddress    = addr_reg;
    assign ramReadSignal = (state_reg == FETCH);
    assign Dout          = dout_reg;
    assign doutValid     = (state_reg == EMIT);
    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);

endmodule

// File: tb/tb_compress_handler.sv
module tb_compress_handler;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [15:0] baseAddress = 16'd0;
    logic [15:0] byteCount = 16'd0;
    logic [15:0] ramAddress;
    logic        ramReadSignal;
    logic        ramDoneRead = 1'b0;
    logic [7:0]  ramDataIn = 8'd0;
    logic [15:0] Dout;
    logic        doutValid;
    logic        doutReady = 1'b1;
    logic        busy;
    logic        done;

    compress_handler dut (
        .clk           (clk),
        .RST           (RST),
        .start         (start),
        .baseAddress   (baseAddress),
        .byteCount     (byteCount),
        .ramAddress    (ramAddress),
        .ramReadSignal (ramReadSignal),
        .ramDoneRead   (ramDoneRead),
        .ramDataIn     (ramDataIn),
        .Dout          (Dout),
        .doutValid     (doutValid),
        .doutReady     (doutReady),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:255];
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];
    logic [15:0] addr_q [$];
    int          done_cnt = 0;
    int          valid_cnt = 0;
    int          read_cnt = 0;
    int          emit_read_viol = 0;
    int          lat_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM responder with two wait cycles per read, plus output monitors.
    always @(negedge clk) begin
        ramDataIn = mem[ramAddress[7:0]];
        if (ramReadSignal && !RST) begin
            ramDoneRead = (lat_cnt == 2);
            if (ramDoneRead) begin
                lat_cnt = 0;
                addr_q.push_back(ramAddress);
            end else begin
                lat_cnt = lat_cnt + 1;
            end
        end else begin
            ramDoneRead = 1'b0;
            lat_cnt = 0;
        end
        if (doutValid && doutReady) got_q.push_back(Dout);
        if (done) done_cnt++;
        if (doutValid) valid_cnt++;
        if (ramReadSignal) read_cnt++;
        if (doutValid && ramReadSignal) emit_read_viol++;
    end

    task automatic add_trailer();
`ifdef COMPRESS_TRAILER_EN
        exp_q.push_back(16'h0000);
`endif
    endtask

    task automatic pulse_start(input logic [15:0] base, input logic [15:0] cnt);
        @(posedge clk); #1;
        baseAddress = base;
        byteCount = cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (done) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_nwords"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic run(input string tag, input logic [15:0] base, input logic [15:0] cnt);
        got_q.delete();
        addr_q.delete();
        pulse_start(base, cnt);
        wait_done(tag);
        compare_words(tag);
    endtask

    initial begin
        int d0, r0, v0;
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hF0;
        for (int i = 8'h20; i < 8'h40; i++) mem[i] = 8'hFF;
        mem[8'h40] = 8'hAA;
        mem[8'h50] = 8'h81;
        mem[8'h51] = 8'h7E;
        mem[8'h60] = 8'h00;
        mem[8'hFF] = 8'h0F;
        mem[8'h00] = 8'hF0;

        // Reset state
        #12;
        check("rst_ramAddress", ramAddress, 16'h0);
        check("rst_Dout", Dout, 16'h0);
        check("rst_ramReadSignal", ramReadSignal, 1'b0);
        check("rst_doutValid", doutValid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(posedge clk); #1;
        RST = 1'b0;

        // Single byte F0
        exp_q = '{16'h0401, 16'h0400};
        add_trailer();
        run("f0", 16'h0010, 16'd1);

        // 32 bytes of FF: 255 + 1 split
        exp_q = '{16'hFF01, 16'h0101};
        add_trailer();
        run("ff32", 16'h0020, 16'd32);

        // Two bytes 81,7E
        exp_q = '{16'h0101, 16'h0600, 16'h0101, 16'h0100, 16'h0601, 16'h0100};
        add_trailer();
        run("mix", 16'h0050, 16'd2);

        // Address wrap FFFF -> 0000, bytes 0F,F0
        exp_q = '{16'h0400, 16'h0801, 16'h0400};
        add_trailer();
        run("wrap", 16'hFFFF, 16'd2);
        check("wrap_naddr", addr_q.size(), 2);
        if (addr_q.size() == 2) begin
            check("wrap_addr0", addr_q[0], 16'hFFFF);
            check("wrap_addr1", addr_q[1], 16'h0000);
        end

        // byteCount = 0
        got_q.delete();
        d0 = done_cnt; r0 = read_cnt; v0 = valid_cnt;
        pulse_start(16'h0010, 16'd0);
`ifdef COMPRESS_TRAILER_EN
        exp_q = '{16'h0000};
        wait_done("zero");
        compare_words("zero");
`else
        check("zero_done_edge2", done, 1'b1);
        @(posedge clk); #1;
        check("zero_done_pulse", done, 1'b0);
        check("zero_busy_after", busy, 1'b0);
        check("zero_valid_cnt", valid_cnt - v0, 0);
        check("zero_nwords", got_q.size(), 0);
`endif
        check("zero_read_cnt", read_cnt - r0, 0);
        check("zero_done_cnt", done_cnt - d0, 1);

        // AA with backpressure on the first word
        got_q.delete();
        doutReady = 1'b0;
        pulse_start(16'h0040, 16'd1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (doutValid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check("aa_valid_seen", seen, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("aa_hold_dout%0d", i), Dout, 16'h0101);
            check($sformatf("aa_hold_rd%0d", i), ramReadSignal, 1'b0);
            check($sformatf("aa_hold_valid%0d", i), doutValid, 1'b1);
            @(posedge clk); #1;
        end
        doutReady = 1'b1;
        exp_q = '{16'h0101, 16'h0100, 16'h0101, 16'h0100,
                  16'h0101, 16'h0100, 16'h0101, 16'h0100};
        add_trailer();
        wait_done("aa");
        compare_words("aa");

        // Reset while a read is outstanding
        got_q.delete();
        d0 = done_cnt;
        pulse_start(16'h0010, 16'd1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (ramReadSignal) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check("abort_read_seen", seen, 1'b1);
        #2 RST = 1'b1;
        #1;
        check("abort_ramAddress", ramAddress, 16'h0);
        check("abort_rd", ramReadSignal, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_valid", doutValid, 1'b0);
        check("abort_Dout", Dout, 16'h0);
        check("abort_done", done, 1'b0);
        @(posedge clk); #1;
        RST = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        exp_q = '{16'h0401, 16'h0400};
        add_trailer();
        run("after_abort", 16'h0010, 16'd1);

`ifdef COMPRESS_TRAILER_EN
        exp_q = '{16'h0800, 16'h0000};
        run("trailer00", 16'h0060, 16'd1);
`endif

        check("emit_no_read", emit_read_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
